// File: rtl/posizione_multipasso.sv
// Multi-step 2-D position integrator: each request runs 1..16 steps, each step
// fetching a signed velocity pair over the soc/eoc handshake and adding it to (x, y).
module posizione_multipasso #(
    parameter int PW = 8,
    parameter int VW = 4
) (
    input  logic          clock,
    input  logic          reset_,
    input  logic          soc_p,
    output logic          eoc_p,
    input  logic [1:0]    mode,
    input  logic [3:0]    n_steps,
    output logic          soc_vx,
    output logic          soc_vy,
    input  logic          eoc_vx,
    input  logic          eoc_vy,
    input  logic [VW-1:0] vx,
    input  logic [VW-1:0] vy,
    output logic [PW-1:0] x,
    output logic [PW-1:0] y,
    output logic          ovf
);

    localparam logic [PW-1:0] POS_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] POS_MIN = {1'b1, {(PW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_REQ,
        S_WAIT,
        S_UPD
    } state_t;

    state_t                state_q;
    logic [1:0]            mode_q;
    logic [4:0]            cnt_q;
    logic                  soc_q;
    logic                  eoc_p_q;
    logic                  ovf_q;
    logic [1:0][PW-1:0]    pos_q;
    logic [1:0][VW-1:0]    vel_q;
    logic [1:0][PW-1:0]    pos_upd;
    logic [1:0]            ax_ovf;

    // Axis 0 is x, axis 1 is y; both use identical, independent arithmetic.
    for (genvar gi = 0; gi < 2; gi++) begin : g_axis
        logic [PW:0] sum;
        logic        ovf_ax;

        assign sum    = {pos_q[gi][PW-1], pos_q[gi]}
                      + {{(PW+1-VW){vel_q[gi][VW-1]}}, vel_q[gi]};
        assign ovf_ax = sum[PW] ^ sum[PW-1];
        assign ax_ovf[gi] = ovf_ax;

        // Overflow needs a nonzero velocity, so its sign picks the clamp rail.
        assign pos_upd[gi] = !ovf_ax           ? sum[PW-1:0] :
                             (mode_q == 2'b01) ? (vel_q[gi][VW-1] ? POS_MIN : POS_MAX) :
                             (mode_q == 2'b10) ? sum[PW-1:0] :
                                                 pos_q[gi];
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            cnt_q   <= 5'd0;
            soc_q   <= 1'b0;
            eoc_p_q <= 1'b1;
            ovf_q   <= 1'b0;
            pos_q   <= '0;
            vel_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (soc_p) begin
                        eoc_p_q <= 1'b0;
                        ovf_q   <= 1'b0;
                        mode_q  <= mode;
                        cnt_q   <= {(n_steps == 4'd0), n_steps};
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!soc_p) begin
                        soc_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!eoc_vx && !eoc_vy) begin
                        soc_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eoc_vx && eoc_vy) begin
                        vel_q[0] <= vx;
                        vel_q[1] <= vy;
                        state_q  <= S_UPD;
                    end
                end
                S_UPD: begin
                    pos_q <= pos_upd;
                    cnt_q <= cnt_q - 5'd1;
                    if (|ax_ovf) begin
                        ovf_q <= 1'b1;
                    end
                    if (cnt_q == 5'd1) begin
                        eoc_p_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        soc_q   <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign eoc_p  = eoc_p_q;
    assign soc_vx = soc_q;
    assign soc_vy = soc_q;
    assign ovf    = ovf_q;
    assign x      = pos_q[0];
    assign y      = pos_q[1];

endmodule
